// File: rtl/tetris_pkg.sv
// Shared types for the game-flow sequencer: command strobe indices, state encoding and
// gameboard flag positions.
package tetris_pkg;

  localparam int unsigned NumCmds = 13;

  typedef enum logic [3:0] {
    CmdClearAll       = 4'd0,
    CmdPiecePlaced    = 4'd1,
    CmdRotateLeft     = 4'd2,
    CmdRotateLeft2    = 4'd3,
    CmdRotateRight    = 4'd4,
    CmdRotateRight2   = 4'd5,
    CmdFall           = 4'd6,
    CmdMoveLeft       = 4'd7,
    CmdMoveRight      = 4'd8,
    CmdClearlineCheck = 4'd9,
    CmdClearlineAct   = 4'd10,
    CmdHold           = 4'd11,
    CmdEndgame        = 4'd12
  } cmd_e;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StClear = 4'd1,
    StSpawn = 4'd2,
    StSpchk = 4'd3,
    StPlay  = 4'd4,
    StRot1  = 4'd5,
    StRot2  = 4'd6,
    StLchk  = 4'd7,
    StLwait = 4'd8,
    StLact  = 4'd9,
    StOver  = 4'd10
  } seq_state_e;

  localparam logic [5:0] CLEARLINE_NONE = 6'd31;

  localparam int unsigned COL_UP    = 0;
  localparam int unsigned COL_DOWN  = 1;
  localparam int unsigned COL_LEFT  = 2;
  localparam int unsigned COL_RIGHT = 3;

  function automatic logic [NumCmds-1:0] cmd_onehot(cmd_e c);
    logic [NumCmds-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/piece_sequencer_fsm_if.sv
// Sequencer <-> gameboard link: command strobes out, placement/collision/row status back.
interface piece_sequencer_fsm_if;

  logic [12:0] cmd;
  logic        spawn_blocked;
  logic [3:0]  collision;
  logic [5:0]  clearlineval;

  modport master (
    output cmd,
    input  spawn_blocked,
    input  collision,
    input  clearlineval
  );

  modport slave (
    input  cmd,
    output spawn_blocked,
    output collision,
    output clearlineval
  );

endinterface

// File: rtl/btn_edge_pend.sv
// Rising-edge detector with a sticky pending flag; a new edge wins over a same-cycle clear.
module btn_edge_pend (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic clr,
  output logic pend
);

  logic prev_q;
  logic pend_q;
  logic rise;

  assign rise = level & ~prev_q;
  assign pend = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= level;
      pend_q <= rise | (pend_q & ~clr);
    end
  end

endmodule

// File: rtl/piece_sequencer_fsm.sv
// Game-flow controller: arbitrates buttons against gravity, runs lock delay and the
// line-clear loop, and issues one-cycle registered command strobes to the gameboard.
module piece_sequencer_fsm
  import tetris_pkg::*;
#(
  parameter int unsigned GRAV_DIV   = 50_000_000,
  parameter int unsigned LOCK_TICKS = 2,
  parameter int unsigned MAX_CLEARS = 30
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   btn_rotl,
  input  logic                   btn_rotr,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_hold,
  piece_sequencer_fsm_if.master  board,
  output logic [15:0]            lines_cleared,
  output logic                   game_over,
  output logic [3:0]             state_o
);

  localparam int unsigned GravW   = $clog2(GRAV_DIV);
  localparam int unsigned LockW   = $clog2(LOCK_TICKS + 1);
  localparam int unsigned GuardW  = $clog2(MAX_CLEARS + 1);
  localparam int unsigned NumBtns = 5;
  // Lower index = higher service priority.
  localparam int unsigned BHold  = 0;
  localparam int unsigned BRotl  = 1;
  localparam int unsigned BRotr  = 2;
  localparam int unsigned BLeft  = 3;
  localparam int unsigned BRight = 4;

  seq_state_e          state_q;
  logic [NumCmds-1:0]  cmd_q;
  logic [GravW-1:0]    grav_q;
  logic [LockW-1:0]    lock_q;
  logic [GuardW-1:0]   guard_q;
  logic                hold_used_q;
  logic                rot_left_q;
  logic [15:0]         lines_q;
  logic                game_over_q;

  logic [NumBtns-1:0]  btn, btn_pend, btn_clr, ok, sel;
  logic                start_pend;
  logic                tick, play_idle;
  logic                unused_col_up;

  assign btn = {btn_right, btn_left, btn_rotr, btn_rotl, btn_hold};

  for (genvar i = 0; i < NumBtns; i++) begin : g_btn
    btn_edge_pend u_pend (
      .clk   (clk),
      .rst_n (rst_n),
      .level (btn[i]),
      .clr   (btn_clr[i]),
      .pend  (btn_pend[i])
    );
  end

  // Start flag is cleared every cycle, so edges outside IDLE/OVER simply vanish.
  btn_edge_pend u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .level (start),
    .clr   (1'b1),
    .pend  (start_pend)
  );

  always_comb begin
    tick      = (state_q == StPlay) && (grav_q == GravW'(GRAV_DIV - 1));
    play_idle = (state_q == StPlay) && !tick;
    ok         = btn_pend;
    ok[BHold]  = btn_pend[BHold] & ~hold_used_q;
    ok[BLeft]  = btn_pend[BLeft] & ~board.collision[COL_LEFT];
    ok[BRight] = btn_pend[BRight] & ~board.collision[COL_RIGHT];
    sel        = ok & (~ok + {{(NumBtns - 1){1'b0}}, 1'b1});
    // Rejected requests drop in the same cycle the winner is served.
    btn_clr = '0;
    if (state_q == StSpawn) begin
      btn_clr = '1;
    end else if (play_idle) begin
      btn_clr = (btn_pend & ~ok) | sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      grav_q      <= '0;
      lock_q      <= '0;
      guard_q     <= '0;
      hold_used_q <= 1'b0;
      rot_left_q  <= 1'b0;
      lines_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      cmd_q <= '0;
      unique case (state_q)
        StIdle, StOver: begin
          if (start_pend) begin
            state_q     <= StClear;
            cmd_q       <= cmd_onehot(CmdClearAll);
            lines_q     <= '0;
            game_over_q <= 1'b0;
          end
        end
        StClear: begin
          state_q     <= StSpawn;
          cmd_q       <= cmd_onehot(CmdPiecePlaced);
          grav_q      <= '0;
          lock_q      <= '0;
          hold_used_q <= 1'b0;
        end
        StSpawn: state_q <= StSpchk;
        StSpchk: begin
          if (board.spawn_blocked) begin
            state_q     <= StOver;
            cmd_q       <= cmd_onehot(CmdEndgame);
            game_over_q <= 1'b1;
          end else begin
            state_q <= StPlay;
          end
        end
        StPlay: begin
          if (tick) begin
            grav_q <= '0;
            if (!board.collision[COL_DOWN]) begin
              cmd_q  <= cmd_onehot(CmdFall);
              lock_q <= '0;
            end else if (lock_q == LockW'(LOCK_TICKS - 1)) begin
              state_q <= StLchk;
              cmd_q   <= cmd_onehot(CmdClearlineCheck);
              lock_q  <= '0;
              guard_q <= '0;
            end else begin
              lock_q <= lock_q + LockW'(1);
            end
          end else begin
            grav_q <= grav_q + GravW'(1);
            if (sel[BHold]) begin
              cmd_q       <= cmd_onehot(CmdHold);
              hold_used_q <= 1'b1;
              grav_q      <= '0;
            end else if (sel[BRotl] || sel[BRotr]) begin
              state_q    <= StRot1;
              rot_left_q <= sel[BRotl];
              cmd_q      <= cmd_onehot(sel[BRotl] ? CmdRotateLeft : CmdRotateRight);
            end else if (sel[BLeft]) begin
              cmd_q  <= cmd_onehot(CmdMoveLeft);
              lock_q <= '0;
            end else if (sel[BRight]) begin
              cmd_q  <= cmd_onehot(CmdMoveRight);
              lock_q <= '0;
            end
          end
        end
        StRot1: begin
          state_q <= StRot2;
          cmd_q   <= cmd_onehot(rot_left_q ? CmdRotateLeft2 : CmdRotateRight2);
        end
        StRot2: state_q <= StPlay;
        StLchk: state_q <= StLwait;
        StLwait: begin
          if (board.clearlineval == CLEARLINE_NONE || guard_q == GuardW'(MAX_CLEARS)) begin
            state_q     <= StSpawn;
            cmd_q       <= cmd_onehot(CmdPiecePlaced);
            grav_q      <= '0;
            lock_q      <= '0;
            hold_used_q <= 1'b0;
          end else begin
            state_q <= StLact;
            cmd_q   <= cmd_onehot(CmdClearlineAct);
            guard_q <= guard_q + GuardW'(1);
            if (lines_q != 16'hFFFF) lines_q <= lines_q + 16'd1;
          end
        end
        StLact: begin
          state_q <= StLchk;
          cmd_q   <= cmd_onehot(CmdClearlineCheck);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign board.cmd     = cmd_q;
  assign lines_cleared = lines_q;
  assign game_over     = game_over_q;
  assign state_o       = state_q;
  assign unused_col_up = board.collision[COL_UP];

endmodule

// File: tb/tb_piece_sequencer_fsm.sv
// Directed bench for piece_sequencer_fsm with GRAV_DIV=8, LOCK_TICKS=2, MAX_CLEARS=30.
module tb_piece_sequencer_fsm;
  import tetris_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic        btn_rotl, btn_rotr, btn_left, btn_right, btn_hold;
  logic [15:0] lines_cleared;
  logic        game_over;
  logic [3:0]  state_o;

  int n_vec = 0;
  int n_bad = 0;
  int seen[13];

  piece_sequencer_fsm_if bus ();

  piece_sequencer_fsm #(
    .GRAV_DIV   (8),
    .LOCK_TICKS (2),
    .MAX_CLEARS (30)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .btn_rotl      (btn_rotl),
    .btn_rotr      (btn_rotr),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_hold      (btn_hold),
    .board         (bus),
    .lines_cleared (lines_cleared),
    .game_over     (game_over),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge; strobes tallied per command.
  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) if (bus.cmd[i]) seen[i]++;
    check("cmd_onehot", 32'($countones(bus.cmd) <= 1), 32'd1);
  endtask

  // Cycles until the given strobe is seen, or -1 when the budget runs out.
  task automatic wait_cmd(input cmd_e c, input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      cyc();
      if (bus.cmd[c]) begin
        n = k;
        break;
      end
    end
  endtask

  int n, snap, snap2, tot0, tot1;

  initial begin
    for (int i = 0; i < 13; i++) seen[i] = 0;
    rst_n = 1'b0; start = 1'b0;
    btn_rotl = 1'b0; btn_rotr = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_hold = 1'b0;
    bus.spawn_blocked = 1'b0; bus.collision = 4'b0000; bus.clearlineval = 6'd31;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_go", 32'(game_over), 32'd0);
    check("rst_state", 32'(state_o), 32'(StIdle));
    rst_n = 1'b1;
    cyc(); cyc();

    // 1: start -> CLEAR_ALL, PIECE_PLACED, PLAY, FALL every 8 cycles
    start = 1'b1;
    wait_cmd(CmdClearAll, 5, n);
    check("start_to_clear", 32'(n), 32'd2);
    cyc(); check("spawn_strobe", 32'(bus.cmd), 32'(cmd_onehot(CmdPiecePlaced)));
    cyc(); check("spchk_quiet", 32'(bus.cmd), 32'd0);
    cyc(); check("play_entry", 32'(state_o), 32'(StPlay));
    start = 1'b0;
    wait_cmd(CmdFall, 12, n); check("fall_gap1", 32'(n), 32'd8);
    wait_cmd(CmdFall, 12, n); check("fall_gap2", 32'(n), 32'd8);

    // 2: rotate left, two consecutive strobes, held button gives one request
    btn_rotl = 1'b1;
    cyc(); check("rot_latency", 32'(bus.cmd), 32'd0);
    cyc(); check("rot1", 32'(bus.cmd), 32'(cmd_onehot(CmdRotateLeft)));
    cyc(); check("rot2", 32'(bus.cmd), 32'(cmd_onehot(CmdRotateLeft2)));
    cyc(); check("rot_back_play", 32'(state_o), 32'(StPlay));
    snap = seen[CmdRotateLeft];
    repeat (17) cyc();
    check("rot_held_once", 32'(seen[CmdRotateLeft] - snap), 32'd0);
    btn_rotl = 1'b0;

    // 3: blocked left dropped, hold before right, second hold ignored
    wait_cmd(CmdFall, 12, n); check("t3_sync", 32'(n > 0), 32'd1);
    bus.collision = 4'b0100;
    btn_left = 1'b1; btn_hold = 1'b1; btn_right = 1'b1;
    cyc(); check("t3_latency", 32'(bus.cmd), 32'd0);
    cyc(); check("hold_first", 32'(bus.cmd), 32'(cmd_onehot(CmdHold)));
    cyc(); check("right_next", 32'(bus.cmd), 32'(cmd_onehot(CmdMoveRight)));
    btn_left = 1'b0; btn_hold = 1'b0; btn_right = 1'b0;
    snap = seen[CmdHold]; snap2 = seen[CmdMoveLeft];
    cyc();
    btn_hold = 1'b1;
    repeat (10) cyc();
    check("hold_twice", 32'(seen[CmdHold] - snap), 32'd0);
    check("left_blocked", 32'(seen[CmdMoveLeft] - snap2), 32'd0);
    btn_hold = 1'b0;

    // 4: lock after two blocked ticks, one line cleared, then respawn
    bus.collision = 4'b0000;
    wait_cmd(CmdFall, 12, n); check("t4_sync", 32'(n > 0), 32'd1);
    bus.collision = 4'b0010; bus.clearlineval = 6'd12;
    snap = seen[CmdFall];
    wait_cmd(CmdClearlineCheck, 20, n); check("lock_delay", 32'(n), 32'd16);
    check("no_fall_blocked", 32'(seen[CmdFall] - snap), 32'd0);
    cyc(); check("lwait_quiet", 32'(bus.cmd), 32'd0);
    cyc(); check("line_act", 32'(bus.cmd), 32'(cmd_onehot(CmdClearlineAct)));
    check("lines_1", 32'(lines_cleared), 32'd1);
    bus.clearlineval = 6'd31; bus.collision = 4'b0000;
    cyc(); check("recheck", 32'(bus.cmd), 32'(cmd_onehot(CmdClearlineCheck)));
    cyc();
    cyc(); check("respawn", 32'(bus.cmd), 32'(cmd_onehot(CmdPiecePlaced)));

    // 5: blocked spawn -> game over; buttons ignored; restart clears status
    bus.spawn_blocked = 1'b1;
    cyc(); check("spchk_state", 32'(state_o), 32'(StSpchk));
    cyc(); check("endgame", 32'(bus.cmd), 32'(cmd_onehot(CmdEndgame)));
    check("go_set", 32'(game_over), 32'd1);
    cyc(); check("endgame_once", 32'(bus.cmd), 32'd0);
    check("go_held", 32'(game_over), 32'd1);
    check("lines_kept", 32'(lines_cleared), 32'd1);
    bus.spawn_blocked = 1'b0;
    tot0 = 0; for (int i = 0; i < 13; i++) tot0 += seen[i];
    btn_rotl = 1'b1; btn_left = 1'b1; btn_hold = 1'b1;
    repeat (6) cyc();
    btn_rotl = 1'b0; btn_left = 1'b0; btn_hold = 1'b0;
    repeat (3) cyc();
    tot1 = 0; for (int i = 0; i < 13; i++) tot1 += seen[i];
    check("over_no_strobe", 32'(tot1 - tot0), 32'd0);
    check("over_state", 32'(state_o), 32'(StOver));
    start = 1'b1;
    wait_cmd(CmdClearAll, 5, n); check("restart", 32'(n), 32'd2);
    check("restart_lines", 32'(lines_cleared), 32'd0);
    check("restart_go", 32'(game_over), 32'd0);
    start = 1'b0;

    // 6: reset mid-ROT1 aborts; stuck full row hits the iteration guard
    cyc(); cyc(); cyc();
    check("t6_play", 32'(state_o), 32'(StPlay));
    btn_rotl = 1'b1;
    cyc();
    cyc(); check("t6_rot1", 32'(bus.cmd), 32'(cmd_onehot(CmdRotateLeft)));
    snap = seen[CmdRotateLeft2];
    rst_n = 1'b0;
    #1;
    check("async_cmd", 32'(bus.cmd), 32'd0);
    check("async_state", 32'(state_o), 32'(StIdle));
    @(posedge clk);
    #1;
    rst_n = 1'b1; btn_rotl = 1'b0;
    repeat (4) cyc();
    check("no_rot2", 32'(seen[CmdRotateLeft2] - snap), 32'd0);
    check("idle_after_rst", 32'(state_o), 32'(StIdle));
    bus.collision = 4'b0010; bus.clearlineval = 6'd5;
    start = 1'b1;
    wait_cmd(CmdClearlineCheck, 40, n); check("t6_lock", 32'(n > 0), 32'd1);
    start = 1'b0;
    snap = seen[CmdClearlineAct];
    wait_cmd(CmdPiecePlaced, 200, n); check("guard_exit", 32'(n > 0), 32'd1);
    check("guard_acts", 32'(seen[CmdClearlineAct] - snap), 32'd30);
    check("lines_30", 32'(lines_cleared), 32'd30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
